// File: rtl/spi_slave_rx.sv
// SPI mode-0 receive-only slave: synchronizes the pins into clk, deserializes MSB-first
// words and queues them in a FIFO that holds at most FIFO_DEPTH-1 words.
module spi_slave_rx #(
    parameter int DATA       = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          sclk,
    input  logic                          cs_n,
    input  logic                          mosi,
    output logic [DATA-1:0]               rdata,
    input  logic                          rd,
    output logic [$clog2(FIFO_DEPTH)-1:0] usedw,
    output logic                          overflow,
    output logic                          frame_err
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = (DATA > 1) ? $clog2(DATA) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA - 1);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [AW-1:0] FULL_LVL = AW'(FIFO_DEPTH - 1);
    localparam logic [AW-1:0] AW_ZERO  = {AW{1'b0}};
    localparam logic [AW-1:0] AW_ONE   = AW'(1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    logic            sclk_meta_r, sclk_sync_r, sclk_prev_r;
    logic            cs_meta_r, cs_sync_r;
    logic            mosi_meta_r, mosi_sync_r;
    logic            sclk_rise_s;
    state_t          state_r, state_nxt_s;
    logic [CW-1:0]   bit_cnt_r;
    logic [DATA-1:0] shift_r;
    logic            shift_en_s, word_done_s, frame_err_s;
    logic            wr_r, frame_err_r;

    logic [DATA-1:0] mem_r [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_r, rd_ptr_r, usedw_r;
    logic [DATA-1:0] rdata_r;
    logic            overflow_r;
    logic            do_rd_s, do_wr_s;

    // Two-flop synchronizers for the SPI pins plus a delayed copy of sclk for edge detection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sclk_meta_r <= 1'b0;
            sclk_sync_r <= 1'b0;
            sclk_prev_r <= 1'b0;
            cs_meta_r   <= 1'b1;
            cs_sync_r   <= 1'b1;
            mosi_meta_r <= 1'b0;
            mosi_sync_r <= 1'b0;
        end else begin
            sclk_meta_r <= sclk;
            sclk_sync_r <= sclk_meta_r;
            sclk_prev_r <= sclk_sync_r;
            cs_meta_r   <= cs_n;
            cs_sync_r   <= cs_meta_r;
            mosi_meta_r <= mosi;
            mosi_sync_r <= mosi_meta_r;
        end
    end

    assign sclk_rise_s = sclk_sync_r & ~sclk_prev_r;

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; chip-select release takes priority over a coincident sclk edge.
    always_comb begin
        state_nxt_s = state_r;
        shift_en_s  = 1'b0;
        word_done_s = 1'b0;
        frame_err_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (!cs_sync_r) begin
                    state_nxt_s = SHIFT;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SHIFT: begin
                if (cs_sync_r) begin
                    state_nxt_s = IDLE;
                    frame_err_s = (bit_cnt_r != CNT_ZERO);
                end else begin
                    state_nxt_s = SHIFT;
                    shift_en_s  = sclk_rise_s;
                    word_done_s = sclk_rise_s && (bit_cnt_r == LAST_BIT);
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Deserializer, bit counter and the registered write / frame-error strobes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_r     <= {DATA{1'b0}};
            bit_cnt_r   <= CNT_ZERO;
            wr_r        <= 1'b0;
            frame_err_r <= 1'b0;
        end else begin
            wr_r        <= word_done_s;
            frame_err_r <= frame_err_s;
            if (shift_en_s) begin
                shift_r   <= {shift_r[DATA-2:0], mosi_sync_r};
                bit_cnt_r <= word_done_s ? CNT_ZERO : (bit_cnt_r + CNT_ONE);
            end else if (state_nxt_s == IDLE) begin
                bit_cnt_r <= CNT_ZERO;
            end else begin
                bit_cnt_r <= bit_cnt_r;
            end
        end
    end

    // A full FIFO still accepts a write when a read frees a slot in the same cycle.
    assign do_rd_s = rd && (usedw_r != AW_ZERO);
    assign do_wr_s = wr_r && ((usedw_r != FULL_LVL) || do_rd_s);

    // FIFO storage; contents are meaningful only between the pointers, so no reset.
    always_ff @(posedge clk) begin
        if (do_wr_s) begin
            mem_r[wr_ptr_r] <= shift_r;
        end
    end

    // FIFO pointers, occupancy, read data register and sticky overflow.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r   <= AW_ZERO;
            rd_ptr_r   <= AW_ZERO;
            usedw_r    <= AW_ZERO;
            rdata_r    <= {DATA{1'b0}};
            overflow_r <= 1'b0;
        end else begin
            if (do_wr_s) begin
                wr_ptr_r <= wr_ptr_r + AW_ONE;
            end
            if (do_rd_s) begin
                rd_ptr_r <= rd_ptr_r + AW_ONE;
                rdata_r  <= mem_r[rd_ptr_r];
            end
            if (wr_r && !do_wr_s) begin
                overflow_r <= 1'b1;
            end
            case ({do_wr_s, do_rd_s})
                2'b10:   usedw_r <= usedw_r + AW_ONE;
                2'b01:   usedw_r <= usedw_r - AW_ONE;
                default: usedw_r <= usedw_r;
            endcase
        end
    end

    assign rdata     = rdata_r;
    assign usedw     = usedw_r;
    assign overflow  = overflow_r;
    assign frame_err = frame_err_r;

endmodule

// File: tb/tb_spi_slave_rx.sv
// Directed bench for spi_slave_rx: SPI frames driven on clk-aligned times, outputs
// checked on falling clk edges against hand-computed values.
module tb_spi_slave_rx;

    logic       clk = 1'b0;
    logic       rst;
    logic       sclk;
    logic       cs_n;
    logic       mosi;
    logic       rd;
    logic [7:0] rdata;
    logic [3:0] usedw;
    logic       overflow;
    logic       frame_err;

    int errors = 0;
    int checks = 0;
    int fe_cnt = 0;

    spi_slave_rx #(.DATA(8), .FIFO_DEPTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .sclk      (sclk),
        .cs_n      (cs_n),
        .mosi      (mosi),
        .rdata     (rdata),
        .rd        (rd),
        .usedw     (usedw),
        .overflow  (overflow),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    // Count clk cycles during which frame_err is high.
    always @(negedge clk) begin
        if (frame_err === 1'b1) fe_cnt <= fe_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic spi_bits(input logic [7:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            mosi = b[7-i];
            #40 sclk = 1'b1;
            #40 sclk = 1'b0;
        end
    endtask

    task automatic cs_low();
        @(negedge clk);
        cs_n = 1'b0;
        #80;
    endtask

    task automatic cs_high();
        #80 cs_n = 1'b1;
        #200;
    endtask

    task automatic read_one(input string tag, input logic [7:0] exp);
        @(negedge clk);
        rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
        check(tag, 32'(rdata), 32'(exp));
    endtask

    initial begin
        rst  = 1'b0;
        sclk = 1'b0;
        cs_n = 1'b1;
        mosi = 1'b0;
        rd   = 1'b0;
        #1;
        check("reset_rdata", 32'(rdata), 32'h0);
        check("reset_usedw", 32'(usedw), 32'h0);
        check("reset_overflow", 32'(overflow), 32'h0);
        check("reset_frame_err", 32'(frame_err), 32'h0);
        #19 rst = 1'b1;
        #40;

        // One frame with nine words, then one read per cycle.
        cs_low();
        for (int w = 0; w < 9; w++) spi_bits(8'(8'h31 + w), 8);
        cs_high();
        check("t1_usedw_peak", 32'(usedw), 32'd9);
        @(negedge clk);
        rd = 1'b1;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            if (i == 8) rd = 1'b0;
            check("t1_rdata", 32'(rdata), 32'(8'h31 + i));
        end
        @(negedge clk);
        check("t1_usedw_empty", 32'(usedw), 32'd0);
        check("t1_overflow", 32'(overflow), 32'd0);

        // Sixteen words with no reads: the last one is dropped.
        cs_low();
        for (int w = 0; w < 16; w++) spi_bits(8'(w), 8);
        cs_high();
        check("t2_usedw_full", 32'(usedw), 32'd15);
        check("t2_overflow", 32'(overflow), 32'd1);
        @(negedge clk);
        rd = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (i == 14) rd = 1'b0;
            check("t2_rdata", 32'(rdata), 32'(i));
        end
        @(negedge clk);
        check("t2_usedw_drained", 32'(usedw), 32'd0);

        // Aborted partial word followed by a good frame.
        fe_cnt = 0;
        cs_low();
        spi_bits(8'hFF, 5);
        cs_high();
        check("t3_frame_err_cycles", 32'(fe_cnt), 32'd1);
        check("t3_usedw_after_abort", 32'(usedw), 32'd0);
        cs_low();
        spi_bits(8'hA5, 8);
        cs_high();
        check("t3_frame_err_total", 32'(fe_cnt), 32'd1);
        check("t3_usedw", 32'(usedw), 32'd1);
        read_one("t3_rdata", 8'hA5);

        // Read requests on an empty FIFO are ignored.
        @(negedge clk);
        rd = 1'b1;
        repeat (10) @(negedge clk);
        rd = 1'b0;
        check("t4_rdata_hold", 32'(rdata), 32'hA5);
        check("t4_usedw_hold", 32'(usedw), 32'd0);

        // Read coinciding with the write strobe at usedw=3.
        cs_low();
        spi_bits(8'h11, 8);
        spi_bits(8'h22, 8);
        spi_bits(8'h33, 8);
        cs_high();
        check("t5_usedw_pre", 32'(usedw), 32'd3);
        cs_low();
        spi_bits(8'h44, 7);
        mosi = 1'b0;
        #40 sclk = 1'b1;
        #30 rd = 1'b1;
        #10 rd = 1'b0;
        sclk = 1'b0;
        check("t5_usedw_same", 32'(usedw), 32'd3);
        check("t5_rdata_oldest", 32'(rdata), 32'h11);
        cs_high();
        read_one("t5_rdata_2", 8'h22);
        read_one("t5_rdata_3", 8'h33);
        read_one("t5_rdata_new_last", 8'h44);
        check("t5_usedw_empty", 32'(usedw), 32'd0);

        // Reset in the middle of a word.
        cs_low();
        spi_bits(8'h77, 8);
        cs_high();
        check("t6_usedw_pre", 32'(usedw), 32'd1);
        check("t6_overflow_sticky", 32'(overflow), 32'd1);
        fe_cnt = 0;
        cs_low();
        spi_bits(8'hFF, 4);
        rst = 1'b0;
        #1;
        check("t6_rst_usedw", 32'(usedw), 32'd0);
        check("t6_rst_rdata", 32'(rdata), 32'd0);
        check("t6_rst_overflow", 32'(overflow), 32'd0);
        check("t6_rst_frame_err", 32'(frame_err), 32'd0);
        #9 cs_n = 1'b1;
        #30 rst = 1'b1;
        #100;
        check("t6_no_frame_err", 32'(fe_cnt), 32'd0);
        check("t6_usedw_post_rst", 32'(usedw), 32'd0);
        cs_low();
        spi_bits(8'h5A, 8);
        cs_high();
        check("t6_usedw_new", 32'(usedw), 32'd1);
        read_one("t6_rdata_new", 8'h5A);
        check("t6_overflow_clear", 32'(overflow), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/spi_slave_rx.md
SPI_SLAVE_RX -- requirements
Module: spi_slave_rx

Interface
REQ-001 SHALL have parameter DATA, default 8, giving the serial word width in bits and the FIFO entry width.
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, giving the FIFO storage depth; it must be a power of two and at least 4.
REQ-003 SHALL have port clk  input  1  system clock; one clock; all state is on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port sclk  input  1  SPI serial clock, asynchronous to clk.
REQ-006 SHALL have port cs_n  input  1  SPI chip select, active-low, asynchronous to clk.
REQ-007 SHALL have port mosi  input  1  SPI serial data in, asynchronous to clk.
REQ-008 SHALL have port rdata  output  DATA  FIFO read data, registered.
REQ-009 SHALL have port rd  input  1  FIFO read request from the downstream consumer.
REQ-010 SHALL have port usedw  output  $clog2(FIFO_DEPTH)  number of stored words.
REQ-011 SHALL have port overflow  output  1  sticky flag: a received word was dropped.
REQ-012 SHALL have port frame_err  output  1  one-cycle pulse: cs_n deasserted mid-word.

Function
REQ-013 SHALL pass sclk, cs_n and mosi through 2-flop synchronizers; clk frequency is at least 4x the sclk frequency.
REQ-014 SHALL implement SPI mode 0: sample on the synchronized sclk rising edge, MSB first.
REQ-015 SHALL use FSM states IDLE and SHIFT: IDLE->SHIFT when synchronized cs_n is low; SHIFT->IDLE when synchronized cs_n is high.
REQ-016 SHALL clear the bit counter (0..DATA-1) on entry to SHIFT and hold it at 0 in IDLE.
REQ-017 SHALL, in SHIFT on each detected sclk rising edge, shift synchronized mosi into the shift register and increment the bit counter.
REQ-018 SHALL, on the DATA-th bit, assert an internal write strobe for exactly one clk cycle on the next cycle, wrap the bit counter to 0, and stay in SHIFT so back-to-back words in one frame are received.
REQ-019 SHALL make a completed word visible in usedw no more than 5 clk cycles after the last sclk rising edge at the pin.
REQ-020 SHALL, on SHIFT->IDLE with bit counter 1..DATA-1, discard the partial word and pulse frame_err high for exactly one cycle.
REQ-021 SHALL limit FIFO capacity to FIFO_DEPTH-1 words, so usedw never wraps.
REQ-022 SHALL treat a read as rd high while usedw>0: on that edge, rdata loads the oldest word (1-cycle latency) and the read pointer advances.
REQ-023 SHALL ignore rd while usedw==0 and hold rdata and usedw unchanged.
REQ-024 SHALL drop a write when usedw==FIFO_DEPTH-1 and no read occurs in the same cycle, and set overflow, which stays set until reset.
REQ-025 SHALL accept a simultaneous read and write, including at full capacity, and leave usedw unchanged.
REQ-026 SHALL wrap read and write pointers modulo FIFO_DEPTH.
REQ-027 SHALL hold rdata at its last value when no read occurs.

Reset
REQ-028 SHALL, on rst low, asynchronously set: FSM=IDLE, bit counter=0, shift register=0, pointers=0, usedw=0, rdata=0, overflow=0, frame_err=0, synchronizers to sclk=0, cs_n=1, mosi=0.
REQ-029 SHALL, on reset asserted mid-word, discard the partial word and all FIFO contents, and not pulse frame_err.
REQ-030 SHALL require the first valid word after rst release to start with a cs_n falling edge.

Verification
REQ-031 SHALL cover: one cs_n frame carrying 0x31..0x39, then read one word per cycle -> usedw peaks at 9, rdata returns 0x31..0x39 in order, overflow=0.
REQ-032 SHALL cover: 16 words 0x00..0x0F sent with no reads -> usedw=15, overflow=1, 0x0F dropped; 15 reads return 0x00..0x0E.
REQ-033 SHALL cover: cs_n raised after 5 bits, then a full frame carrying 0xA5 -> one frame_err pulse, usedw increments by exactly 1, read returns 0xA5.
REQ-034 SHALL cover: rd held high with usedw=0 for 10 cycles -> rdata and usedw unchanged.
REQ-035 SHALL cover: usedw=3 with rd coinciding with the write strobe -> usedw stays 3, the oldest word is output, and the new word is stored last.
REQ-036 SHALL cover: rst low after 4 bits of a word -> all outputs at their reset values immediately; after release, a new frame carrying 0x5A gives usedw=1 and rdata=0x5A on read.
